// File: rtl/parking_gate_arbiter_pkg.sv
// Shared types and defaults for the car-park gate arbiter.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN_IN,
    OPEN_OUT,
    CLOSE
  } gate_state_t;

  typedef enum logic {
    ENTRY,
    EXIT
  } lane_t;

  localparam int DEF_CAPACITY    = 8;
  localparam int DEF_OPEN_CYCLES = 4;

endpackage

// File: rtl/parking_gate_arbiter_occupancy_counter.sv
// Saturating up/down lot occupancy counter with full/empty flags.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  localparam int CNT_W   = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !empty) begin
      count <= count - 1'b1;
    end
  end

  always_comb begin
    full  = (count == CNT_W'(CAPACITY));
    empty = (count == '0);
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Round-robin barrier gate arbiter between entry and exit lanes with occupancy tracking.
// Optional reject statistics output enabled by defining PARK_STATS_EN.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES,
  localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             entry_req,
  input  logic             entry_auth,
  input  logic             exit_req,
  input  logic             pass_sensor,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             busy
`ifdef PARK_STATS_EN
  ,
  output logic [15:0]      reject_cnt
`endif
);

  localparam int TMR_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_CYCLES - 1);

  gate_state_t      state;
  lane_t            last_served;
  logic [TMR_W-1:0] timer;
  logic             ein;
  logic             eout;
  logic             pass_in;
  logic             pass_out;

  always_comb begin
    ein      = entry_req & entry_auth & ~full;
    eout     = exit_req & ~empty;
    pass_in  = (state == OPEN_IN) & pass_sensor;
    pass_out = (state == OPEN_OUT) & pass_sensor;
    busy     = (state != IDLE);
  end

  parking_occupancy_counter #(
    .CAPACITY (CAPACITY)
  ) u_occ (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (pass_in),
    .dec     (pass_out),
    .count   (occupancy),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gate_open   <= 1'b0;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      timer       <= '0;
      last_served <= EXIT;
    end else begin
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      case (state)
        IDLE: begin
          // On a tie the lane that was not served last wins.
          if (ein && (!eout || last_served == EXIT)) begin
            state       <= OPEN_IN;
            gate_open   <= 1'b1;
            grant_entry <= 1'b1;
            timer       <= TMR_LOAD;
            last_served <= ENTRY;
          end else if (eout) begin
            state       <= OPEN_OUT;
            gate_open   <= 1'b1;
            grant_exit  <= 1'b1;
            timer       <= TMR_LOAD;
            last_served <= EXIT;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (pass_sensor || timer == '0) begin
            state     <= CLOSE;
            gate_open <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        CLOSE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARK_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reject_cnt <= '0;
    end else if (state == IDLE && entry_req && entry_auth && full && reject_cnt != '1) begin
      reject_cnt <= reject_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
- Shares the single barrier gate of the car park between an entry lane and an exit lane.
- Tracks lot occupancy and refuses entry when the lot is full.
- Sits downstream of the per-lane password/sensor FSMs: entry_auth comes from the entry-lane password check, and gate_open drives the barrier actuator.
- Round-robin arbitration when both lanes request in the same cycle.

Parameters:
- CAPACITY, 8: number of parking slots; legal range 1..255.
- OPEN_CYCLES, 4: cycles the gate stays open waiting for a car to pass; must be >= 1.
- CNT_W: localparam, $clog2(CAPACITY+1); occupancy width. Not overridable.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- entry_req  in  1  level; car waiting at entrance.
- entry_auth  in  1  level; entrance password accepted.
- exit_req  in  1  level; car waiting at exit.
- pass_sensor  in  1  one-cycle pulse; car cleared the gate.
- gate_open  out  1  barrier open command.
- grant_entry  out  1  one-cycle pulse; entry lane granted.
- grant_exit  out  1  one-cycle pulse; exit lane granted.
- occupancy  out  CNT_W  cars currently inside.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: state IDLE, gate_open 0, grants 0, occupancy 0, timer 0, last_served = EXIT (so entry wins the first tie). full = (CAPACITY==0 ? 1 : 0), empty 1.
- All outputs are registered. full, empty and busy are decoded from registered state/occupancy.
- Eligibility, evaluated in IDLE:
  - ein = entry_req & entry_auth & ~full
  - eout = exit_req & ~empty
- FSM states: IDLE, OPEN_IN, OPEN_OUT, CLOSE.
- IDLE:
  - ein only -> OPEN_IN.
  - eout only -> OPEN_OUT.
  - Both -> the lane not equal to last_served.
  - Neither -> stay in IDLE.
  - On the transition: pulse the matching grant for one cycle, load timer = OPEN_CYCLES-1, update last_served.
- OPEN_IN / OPEN_OUT:
  - gate_open = 1.
  - pass_sensor -> CLOSE; occupancy +1 (IN) or -1 (OUT) in the same edge.
  - Else timer == 0 -> CLOSE with no count change.
  - Else timer decrements.
  - pass_sensor and timer == 0 in the same cycle: the pass wins and the count updates.
- CLOSE: gate_open = 0 for exactly one cycle, then IDLE. Requests in CLOSE are not sampled.
- Timing: request-to-gate_open latency is 1 cycle; minimum grant-to-grant spacing is 3 cycles.
- Saturation:
  - occupancy never exceeds CAPACITY and never underflows.
  - Eligibility gating guarantees this by construction.
  - pass_sensor outside OPEN_* states is ignored.
- Full lot: entry requests stay pending (not dropped) and exit requests are still served. Once the exit pass drops occupancy, entry becomes eligible on the next IDLE cycle.
- entry_auth deasserting while in OPEN_IN does not close the gate early.
- Reset asserted mid-operation: gate_open drops asynchronously and occupancy clears to 0.

Optional Feature:
- Macro: PARK_STATS_EN.
- Defined:
  - Adds output reject_cnt [15:0], reset 0.
  - Increments once per IDLE cycle in which entry_req & entry_auth & full holds.
  - Saturates at 16'hFFFF.
- Undefined: the port and its logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package parking_pkg holds:
  - the gate_state_t enum (IDLE, OPEN_IN, OPEN_OUT, CLOSE);
  - the lane_t enum (ENTRY, EXIT);
  - the default CAPACITY and OPEN_CYCLES constants.
- One sub-module, parking_occupancy_counter:
  - up/down saturating counter with inc/dec inputs;
  - produces full and empty;
  - parameterised by CAPACITY.

Test Plan:
- Reset, then entry_req=1, entry_auth=1 -> grant_entry pulses at cycle 1 and gate_open high from cycle 1. pass_sensor at cycle 2 -> occupancy=1, gate_open low for one cycle, busy returns 0.
- entry_req & exit_req held with occupancy=3 -> grants alternate ENTRY, EXIT, ENTRY..., 3 cycles apart when passes arrive immediately.
- Fill to CAPACITY=8 with entry_req held -> full=1 and no grant_entry. exit_req + pass -> occupancy=7, then grant_entry follows on the next IDLE cycle.
- Grant with no pass_sensor -> gate_open high exactly OPEN_CYCLES=4 cycles, occupancy unchanged. Pass coinciding with the last open cycle -> count updates.
- reset_n low while in OPEN_OUT with occupancy=5 -> gate_open=0 and occupancy=0 immediately. exit_req with empty=1 -> never granted.
- PARK_STATS_EN defined, full, entry_req&entry_auth held 10 IDLE cycles -> reject_cnt=10.
